// File: rtl/xlr_mem_accum.sv
// xlr_mem_accum: multi-bank memory accumulate engine.
// On an accepted start it reads len consecutive words from every bank in
// parallel, sums them per bank, writes each bank's sum back to dst_addr and
// pulses done.
// Optional feature macro: XLR_ACC_SAT_EN (saturating accumulate). When it is
// undefined, sums wrap modulo 2^DATA_W.
//
// Control protocol: start is a single-cycle request that is accepted only in
// IDLE. Any start seen in another state is dropped. busy is high from the
// cycle after an accepted start through the done cycle. done pulses for one
// cycle. Memory read data is expected one cycle after mem_rd_en.
module xlr_mem_accum #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        len,
  input  logic [ADDR_W-1:0]        src_base,
  input  logic [ADDR_W-1:0]        dst_addr,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH-1:0]        mem_rd_en,
  output logic [NUM_CH-1:0]        mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [NUM_CH*DATA_W-1:0] mem_wdata,
  input  logic [NUM_CH*DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_nxt;

  logic [ADDR_W-1:0] len_q, src_q, dst_q;
  logic [ADDR_W-1:0] cnt_q, cnt_nxt;   // reads issued so far
  logic              acc_en_q;         // rdata of a previous read is valid now
  logic              cap, clr_sum;
  logic              rd_nxt, wr_nxt, done_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [NUM_CH*DATA_W-1:0] wdata_nxt;

  logic [DATA_W-1:0] sum_q   [NUM_CH];
  logic [DATA_W-1:0] sum_acc [NUM_CH];  // sum_q plus the current read data
  logic [DATA_W-1:0] sum_cur [NUM_CH];  // sum after this cycle's accumulate
  logic [DATA_W:0]   ext     [NUM_CH];
  logic [NUM_CH-1:0] carry;

  // Per-channel adder with carry detect; wrap or clamp on carry.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ext[c]   = {1'b0, sum_q[c]} + {1'b0, mem_rdata[c*DATA_W +: DATA_W]};
      carry[c] = ext[c][DATA_W];
`ifdef XLR_ACC_SAT_EN
      // Once clamped, any further nonzero add carries again, so the sum
      // stays pinned at the maximum for the rest of the operation.
      sum_acc[c] = carry[c] ? {DATA_W{1'b1}} : ext[c][DATA_W-1:0];
`else
      sum_acc[c] = ext[c][DATA_W-1:0];
`endif
      sum_cur[c] = acc_en_q ? sum_acc[c] : sum_q[c];
    end
  end

  // Next-state and next-output logic. All outputs are registered from these.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    cap       = 1'b0;
    clr_sum   = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    done_nxt  = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          clr_sum = 1'b1;
          if (len != '0) begin
            state_nxt = READ;
            rd_nxt    = 1'b1;
            addr_nxt  = src_base;
            cnt_nxt   = ADDR_W'(1);
          end else begin
            // Empty operation: write the cleared (zero) sums immediately.
            state_nxt = WRITE;
            wr_nxt    = 1'b1;
            addr_nxt  = dst_addr;
          end
        end
      end
      READ: begin
        if (cnt_q == len_q) begin
          state_nxt = DRAIN;
        end else begin
          rd_nxt   = 1'b1;
          addr_nxt = src_q + cnt_q;   // wraps modulo 2^ADDR_W
          cnt_nxt  = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // The last read's data is absorbed this cycle, so the write data
        // must include it: take the post-accumulate value.
        state_nxt = WRITE;
        wr_nxt    = 1'b1;
        addr_nxt  = dst_q;
        for (int c = 0; c < NUM_CH; c++) begin
          wdata_nxt[c*DATA_W +: DATA_W] = sum_cur[c];
        end
      end
      WRITE: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
        clr_sum   = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and captured operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      acc_en_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      acc_en_q <= mem_rd_en[0];
      if (cap) begin
        len_q <= len;
        src_q <= src_base;
        dst_q <= dst_addr;
      end
    end
  end

  // Per-channel sums and sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
      for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
    end else begin
      if (cap) begin
        ovf <= '0;
      end else if (acc_en_q) begin
        ovf <= ovf | carry;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_sum) begin
          sum_q[c] <= '0;
        end else if (acc_en_q) begin
          sum_q[c] <= sum_acc[c];
        end
      end
    end
  end

  // Registered control and memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= '0;
      mem_wr_en <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      mem_rd_en <= {NUM_CH{rd_nxt}};
      mem_wr_en <= {NUM_CH{wr_nxt}};
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

endmodule
